// File: rtl/switch_led_pkg.sv
// Shared constants and helpers for the debounced switch-to-LED path.
// Display mode encodings and counter sizing.
package switch_led_pkg;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_TOGGLE = 2'b01;
  localparam logic [1:0] MODE_BLINK  = 2'b10;
  localparam logic [1:0] MODE_INVERT = 2'b11;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: two-flop synchroniser, hold counter,
// accepted level and a one-cycle pulse on each accepted change.
module debounce_channel
  import switch_led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_stable,
  output logic o_changed
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_stable;
  logic          r_changed;
  logic [CW-1:0] r_cnt;

  // Any sample matching the accepted level restarts the hold count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_stable  <= 1'b0;
      r_changed <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_s1      <= i_raw;
      r_s2      <= r_s1;
      r_changed <= 1'b0;
      if (r_s2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CMAX) begin
        r_stable  <= r_s2;
        r_cnt     <= '0;
        r_changed <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable  = r_stable;
  assign o_changed = r_changed;

endmodule

// File: rtl/switch_debounce_leds.sv
// N debounced switches driving N registered LEDs through a
// runtime display mode: direct, toggle latch, blink or invert.
module switch_debounce_leds
  import switch_led_pkg::*;
#(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BLINK_DIV       = 12500000
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_switch,
  input  logic [1:0]   i_mode,
  output logic [N-1:0] o_LED,
  output logic [N-1:0] o_changed
);

  localparam int BW = cnt_w(BLINK_DIV);
  localparam logic [BW-1:0] BMAX = BW'(BLINK_DIV - 1);

  logic [N-1:0]  w_stable;
  logic [N-1:0]  w_changed;
  logic [N-1:0]  w_toggle_nxt;
  logic [N-1:0]  w_led_nxt;
  logic [N-1:0]  r_toggle;
  logic [N-1:0]  r_led;
  logic [BW-1:0] r_bcnt;
  logic          r_phase;

  for (genvar g = 0; g < N; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_raw    (i_switch[g]),
      .o_stable (w_stable[g]),
      .o_changed(w_changed[g])
    );
  end

  // A change pulse with the new level high marks a rising edge.
  assign w_toggle_nxt = r_toggle ^ (w_changed & w_stable);

  always_comb begin
    w_led_nxt = w_stable;
    unique case (i_mode)
      MODE_DIRECT: w_led_nxt = w_stable;
      MODE_TOGGLE: w_led_nxt = w_toggle_nxt;
      MODE_BLINK:  w_led_nxt = w_stable & {N{r_phase}};
      MODE_INVERT: w_led_nxt = ~w_stable;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_toggle <= '0;
      r_led    <= '0;
      r_bcnt   <= '0;
      r_phase  <= 1'b0;
    end else begin
      r_toggle <= w_toggle_nxt;
      r_led    <= w_led_nxt;
      if (r_bcnt == BMAX) begin
        r_bcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_bcnt <= r_bcnt + 1'b1;
      end
    end
  end

  assign o_LED     = r_led;
  assign o_changed = w_changed;

endmodule

// File: tb/tb_switch_debounce_leds.sv
// Bench for switch_debounce_leds: vector table plus scoreboard
// of expectations scheduled by cycle when stimulus is driven.
module tb_switch_debounce_leds;

  localparam int N  = 4;
  localparam int DB = 4;
  localparam int BD = 3;

  logic         clk  = 1'b0;
  logic         rst  = 1'b0;
  logic [N-1:0] sw   = '0;
  logic [1:0]   mode = 2'b00;
  logic [N-1:0] led;
  logic [N-1:0] chg;

  switch_debounce_leds #(
    .N              (N),
    .DEBOUNCE_CYCLES(DB),
    .BLINK_DIV      (BD)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_switch (sw),
    .i_mode   (mode),
    .o_LED    (led),
    .o_changed(chg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [3:0] led;
    logic [3:0] chg;
    bit         cl;
    bit         cc;
    string      name;
  } exp_t;

  typedef struct {
    logic [3:0] sw;
    logic [1:0] mode;
    logic [3:0] led;
    logic [3:0] chg;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[6];
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic cmp(input string nm, input logic [3:0] act,
                     input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic expect_at(input int due, input bit cl,
                           input logic [3:0] l, input bit cc,
                           input logic [3:0] c, input string nm);
    exp_t e;
    e.due  = due;
    e.cl   = cl;
    e.led  = l;
    e.cc   = cc;
    e.chg  = c;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        if (sb[i].cl) cmp({sb[i].name, " led"}, led, sb[i].led);
        if (sb[i].cc) cmp({sb[i].name, " chg"}, chg, sb[i].chg);
        sb.delete(i);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Asserted between edges so the clear must be asynchronous.
  task automatic rst_on();
    #2 rst = 1'b1;
    #1;
    cmp("rst async", led, 4'b0000);
    cmp("rst async chg", chg, 4'b0000);
    tick();
    tick();
    cmp("rst hold", led, 4'b0000);
  endtask

  task automatic rst_off(output int r);
    rst = 1'b0;
    r   = cyc;
  endtask

  task automatic sw_change(input logic [3:0] nsw, input logic [3:0] old_led,
                           input logic [3:0] new_led, input logic [3:0] cexp,
                           input string nm);
    int c;
    c  = cyc;
    sw = nsw;
    expect_at(c + DB + 1, 0, 4'b0, 1, 4'b0, {nm, " pre"});
    expect_at(c + DB + 2, 1, old_led, 1, cexp, nm);
    expect_at(c + DB + 3, 1, new_led, 1, 4'b0, {nm, " post"});
  endtask

  initial begin
    int         r;
    int         c;
    logic [3:0] cur_sw;
    logic [3:0] cur_led;
    logic [3:0] tl;

    tbl[0] = '{4'b0101, 2'b00, 4'b0101, 4'b1010};
    tbl[1] = '{4'b0101, 2'b11, 4'b1010, 4'b0000};
    tbl[2] = '{4'b0011, 2'b11, 4'b1100, 4'b0110};
    tbl[3] = '{4'b0011, 2'b00, 4'b0011, 4'b0000};
    tbl[4] = '{4'b1100, 2'b00, 4'b1100, 4'b1111};
    tbl[5] = '{4'b0000, 2'b00, 4'b0000, 4'b1100};

    sw = 4'b1111;
    rst_on();
    rst_off(r);
    expect_at(r + 5, 0, 4'b0, 1, 4'b0000, "rst release pre");
    expect_at(r + 6, 1, 4'b0000, 1, 4'b1111, "rst release");
    expect_at(r + 7, 1, 4'b1111, 1, 4'b0000, "rst release post");
    idle(10);

    cur_sw  = 4'b1111;
    cur_led = 4'b1111;
    foreach (tbl[i]) begin
      if (tbl[i].sw != cur_sw) begin
        sw_change(tbl[i].sw, cur_led, tbl[i].led, tbl[i].chg,
                  $sformatf("vec%0d", i));
      end else begin
        mode = tbl[i].mode;
        expect_at(cyc + 1, 1, tbl[i].led, 1, 4'b0,
                  $sformatf("vec%0d mode", i));
        expect_at(cyc + 2, 1, tbl[i].led, 1, 4'b0,
                  $sformatf("vec%0d hold", i));
      end
      idle(10);
      cur_sw  = tbl[i].sw;
      cur_led = tbl[i].led;
    end

    c = cyc;
    for (int k = 1; k <= 12; k++)
      expect_at(c + k, 1, 4'b0, 1, 4'b0, "bounce");
    sw = 4'b0001; tick();
    sw = 4'b0000; tick();
    sw = 4'b0001; tick();
    sw = 4'b0000;
    idle(12);

    c = cyc;
    for (int k = 1; k <= 12; k++)
      expect_at(c + k, 1, 4'b0, 1, 4'b0, "pulse3");
    sw = 4'b0001;
    idle(3);
    sw = 4'b0000;
    idle(12);

    sw_change(4'b0001, 4'b0000, 4'b0001, 4'b0001, "pulse5 rise");
    idle(5);
    sw_change(4'b0000, 4'b0001, 4'b0000, 4'b0001, "pulse5 fall");
    idle(10);

    rst_on();
    sw   = 4'b0000;
    mode = 2'b01;
    rst_off(r);
    expect_at(r + 1, 1, 4'b0000, 1, 4'b0, "tog start");
    idle(3);
    tl = 4'b0000;
    for (int p = 0; p < 3; p++) begin
      sw_change(4'b0100, tl, tl ^ 4'b0100, 4'b0100,
                $sformatf("tog press%0d", p));
      tl = tl ^ 4'b0100;
      idle(10);
      sw_change(4'b0000, tl, tl, 4'b0100,
                $sformatf("tog release%0d", p));
      expect_at(cyc + 10, 1, tl, 1, 4'b0, $sformatf("tog held%0d", p));
      idle(10);
    end

    rst_on();
    sw = 4'b0000;
    rst_off(r);
    idle(3);
    sw_change(4'b0001, 4'b0000, 4'b0001, 4'b0001, "mid latch");
    idle(10);
    sw = 4'b0110;
    idle(2);
    rst_on();
    rst_off(r);
    expect_at(r + 1, 1, 4'b0000, 1, 4'b0, "mid cleared");
    sw_change(4'b0110, 4'b0000, 4'b0110, 4'b0110, "mid redeb");
    idle(10);

    rst_on();
    sw   = 4'b1010;
    mode = 2'b10;
    rst_off(r);
    for (int k = 1; k <= 24; k++)
      expect_at(r + k, 1,
                (k >= 7 && ((k - 1) / 3) % 2 == 1) ? 4'b1010 : 4'b0000,
                0, 4'b0, $sformatf("blink k%0d", k));
    idle(26);

    repeat (20) if (sb.size() != 0) tick();
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard drain: %0d left, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
